// File: rtl/adc_sequencer.sv
// SPI framing controller for a serial multi-channel ADC: round-robins enabled
// channels, captures the trailing data bits, and hands samples out on valid/ready.
module adc_sequencer #(
  parameter int ADC_DATLEN = 12,
  parameter int FRAME_LEN  = 16,
  parameter int CH_W       = 3,
  parameter int NUM_CH     = 8,
  parameter int SCLK_DIV   = 2,
  parameter int CONV_GAP   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [NUM_CH-1:0]     ch_mask,
  output logic                  adc_cs_n,
  output logic                  adc_sclk,
  output logic                  adc_din,
  input  logic                  adc_dout,
  output logic [ADC_DATLEN-1:0] sample_data,
  output logic [CH_W-1:0]       sample_ch,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  overrun
);

  localparam int HW = $clog2(2*FRAME_LEN+2);
  localparam int DW = $clog2(SCLK_DIV+1);
  localparam int GW = $clog2(CONV_GAP+1);

  typedef enum logic [1:0] {IDLE, FRAME, GAP} state_t;

  state_t                state;
  logic [DW-1:0]         div;
  logic [HW-1:0]         half;
  logic [GW-1:0]         gcnt;
  logic [CH_W-1:0]       ptr, cur_ch, nxt_ch;
  logic [ADC_DATLEN-1:0] shreg;
  logic                  start, idle_like, din_bit, cap_bit;
  int                    idx, kf, kr;

  // Lowest enabled channel at or after the pointer, wrapping; descending scan
  // so the nearest hit is the one that sticks.
  always_comb begin
    nxt_ch = '0;
    idx    = 0;
    for (int i = NUM_CH-1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (ch_mask[idx]) nxt_ch = CH_W'(idx);
    end
  end

  // half counts SCLK half-periods: odd = falling edge of bit (half+1)/2,
  // even = rising edge of bit half/2.
  always_comb begin
    kf      = (int'(half) + 1) / 2;
    kr      = int'(half) / 2;
    din_bit = 1'b0;
    for (int j = 0; j < CH_W; j++)
      if (kf == CH_W + 2 - j) din_bit = cur_ch[j];
    cap_bit = kr > FRAME_LEN - ADC_DATLEN;
  end

  assign start     = enable && (|ch_mask);
  assign idle_like = (state == IDLE) || (state == GAP && gcnt == GW'(CONV_GAP));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      div          <= '0;
      half         <= '0;
      gcnt         <= '0;
      ptr          <= '0;
      cur_ch       <= '0;
      shreg        <= '0;
      adc_cs_n     <= 1'b1;
      adc_sclk     <= 1'b1;
      adc_din      <= 1'b0;
      sample_data  <= '0;
      sample_ch    <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (sample_valid && sample_ready) sample_valid <= 1'b0;

      if (idle_like) begin
        if (start) begin
          state    <= FRAME;
          adc_cs_n <= 1'b0;
          cur_ch   <= nxt_ch;
          div      <= DW'(1);
          half     <= HW'(1);
          shreg    <= '0;
        end else begin
          state <= IDLE;
          if (state == IDLE && !enable) overrun <= 1'b0;
        end
      end else if (state == GAP) begin
        gcnt <= gcnt + GW'(1);
      end else if (div == DW'(SCLK_DIV)) begin
        div  <= DW'(1);
        half <= half + HW'(1);
        if (half == HW'(2*FRAME_LEN+1)) begin
          adc_cs_n     <= 1'b1;
          adc_din      <= 1'b0;
          sample_data  <= shreg;
          sample_ch    <= cur_ch;
          sample_valid <= 1'b1;
          // A same-cycle ready means the old sample was taken, not lost.
          if (sample_valid && !sample_ready) overrun <= 1'b1;
          ptr   <= (cur_ch == CH_W'(NUM_CH-1)) ? '0 : cur_ch + CH_W'(1);
          gcnt  <= GW'(1);
          state <= GAP;
        end else if (half[0]) begin
          adc_sclk <= 1'b0;
          adc_din  <= din_bit;
        end else begin
          adc_sclk <= 1'b1;
          if (cap_bit) shreg <= {shreg[ADC_DATLEN-2:0], adc_dout};
        end
      end else begin
        div <= div + DW'(1);
      end
    end
  end

endmodule
